// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet table, collision scanner and renderer:
// color codes, packed pos/size field slices and the scanner state encoding.
package bullet_pkg;

  typedef enum logic [1:0] {
    COLOR_WHITE = 2'd0,
    COLOR_GREEN = 2'd1,
    COLOR_BLUE  = 2'd2,
    COLOR_RSVD  = 2'd3
  } color_e;

  // pos = {x, y}, size = {width, height}
  localparam int X_HI = 15;
  localparam int X_LO = 8;
  localparam int Y_HI = 7;
  localparam int Y_LO = 0;
  localparam int W_HI = 15;
  localparam int W_LO = 8;
  localparam int H_HI = 7;
  localparam int H_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_CHECK,
    ST_COLLIDE,
    ST_DONE
  } scan_state_e;

  typedef enum logic [1:0] {
    EFF_NONE,
    EFF_DAMAGE,
    EFF_HEAL
  } effect_e;

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test on two packed {x,y}/{w,h} boxes.
// Edge sums are 9 bits wide so boxes near 255 never wrap around.
module aabb_overlap
  import bullet_pkg::*;
(
  input  logic [15:0] a_pos,
  input  logic [15:0] a_size,
  input  logic [15:0] b_pos,
  input  logic [15:0] b_size,
  output logic        overlap
);

  logic [8:0] ax_end, bx_end, ay_end, by_end;
  logic       x_ov, y_ov, nonzero;

  always_comb begin
    ax_end  = {1'b0, a_pos[X_HI:X_LO]} + {1'b0, a_size[W_HI:W_LO]};
    bx_end  = {1'b0, b_pos[X_HI:X_LO]} + {1'b0, b_size[W_HI:W_LO]};
    ay_end  = {1'b0, a_pos[Y_HI:Y_LO]} + {1'b0, a_size[H_HI:H_LO]};
    by_end  = {1'b0, b_pos[Y_HI:Y_LO]} + {1'b0, b_size[H_HI:H_LO]};
    x_ov    = ({1'b0, b_pos[X_HI:X_LO]} < ax_end) && ({1'b0, a_pos[X_HI:X_LO]} < bx_end);
    y_ov    = ({1'b0, b_pos[Y_HI:Y_LO]} < ay_end) && ({1'b0, a_pos[Y_HI:Y_LO]} < by_end);
    // A degenerate box would otherwise still pass the strict-inequality test.
    nonzero = (|a_size[W_HI:W_LO]) && (|a_size[H_HI:H_LO]) &&
              (|b_size[W_HI:W_LO]) && (|b_size[H_HI:H_LO]);
    overlap = nonzero && x_ov && y_ov;
  end

endmodule

// File: rtl/bullet_collision_scanner.sv
// Sweeps the bullet table once per start pulse, tests each active bullet against
// the heart box, clears hit bullets and applies damage/heal to player HP.
module bullet_collision_scanner
  import bullet_pkg::*;
#(
  parameter int NUM_BULLETS  = 8,
  parameter int MAX_HP       = 20,
  parameter int DAMAGE       = 4,
  parameter int HEAL         = 2,
  parameter int INVULN_SCANS = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] player_pos,
  input  logic [15:0] player_size,
  input  logic        player_moving,
  input  logic [15:0] bullet_pos,
  input  logic [15:0] bullet_size,
  input  logic [1:0]  bullet_color,
  input  logic        bullet_render,
  output logic [2:0]  bullet_index,
  output logic        is_collide,
  output logic [7:0]  hp,
  output logic        hit,
  output logic        scan_done,
  output logic        dead
);

  localparam logic [2:0] LAST_IDX   = 3'(NUM_BULLETS - 1);
  localparam logic [7:0] MAX_HP_C   = 8'(MAX_HP);
  localparam logic [7:0] DAMAGE_C   = 8'(DAMAGE);
  localparam logic [8:0] HEAL_C     = 9'(HEAL);
  localparam logic [7:0] INVULN_C   = 8'(INVULN_SCANS);

  scan_state_e state_q, state_d;
  effect_e     eff_q, eff_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  hp_q, hp_d;
  logic [7:0]  invuln_q, invuln_d;
  logic        inv_set_q, inv_set_d;
  logic        is_collide_q, is_collide_d;
  logic        hit_q, hit_d;
  logic        scan_done_q, scan_done_d;
  logic        dead_q, dead_d;

  logic        overlap;
  effect_e     eff_now;
  logic        advance;
  logic [8:0]  heal_sum;

  aabb_overlap u_aabb (
    .a_pos   (player_pos),
    .a_size  (player_size),
    .b_pos   (bullet_pos),
    .b_size  (bullet_size),
    .overlap (overlap)
  );

  always_comb begin
    eff_now = EFF_NONE;
    if (bullet_render && overlap && !dead_q && (hp_q != 8'd0)) begin
      unique case (color_e'(bullet_color))
        COLOR_WHITE: if (invuln_q == 8'd0) eff_now = EFF_DAMAGE;
        COLOR_BLUE:  if (invuln_q == 8'd0 && player_moving) eff_now = EFF_DAMAGE;
        COLOR_GREEN: eff_now = EFF_HEAL;
        default:     eff_now = EFF_NONE;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    eff_d        = eff_q;
    idx_d        = idx_q;
    hp_d         = hp_q;
    invuln_d     = invuln_q;
    inv_set_d    = inv_set_q;
    is_collide_d = 1'b0;
    hit_d        = 1'b0;
    scan_done_d  = 1'b0;
    dead_d       = (hp_q == 8'd0);
    advance      = 1'b0;
    heal_sum     = {1'b0, hp_q} + HEAL_C;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !dead_q) begin
          state_d   = ST_SET;
          idx_d     = 3'd0;
          inv_set_d = 1'b0;
        end
      end
      ST_SET: state_d = ST_CHECK;
      ST_CHECK: begin
        if (eff_now != EFF_NONE) begin
          state_d      = ST_COLLIDE;
          eff_d        = eff_now;
          is_collide_d = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      ST_COLLIDE: begin
        if (eff_q == EFF_DAMAGE) begin
          hp_d      = (hp_q > DAMAGE_C) ? hp_q - DAMAGE_C : 8'd0;
          hit_d     = 1'b1;
          invuln_d  = INVULN_C;
          inv_set_d = 1'b1;
        end else if (eff_q == EFF_HEAL) begin
          hp_d = (heal_sum > {1'b0, MAX_HP_C}) ? MAX_HP_C : heal_sum[7:0];
        end
        advance = 1'b1;
      end
      ST_DONE: begin
        scan_done_d = 1'b1;
        // The scan that armed invulnerability does not consume one of its scans.
        if (invuln_q != 8'd0 && !inv_set_q) invuln_d = invuln_q - 8'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        state_d = ST_DONE;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = ST_SET;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      eff_q        <= EFF_NONE;
      idx_q        <= 3'd0;
      hp_q         <= MAX_HP_C;
      invuln_q     <= 8'd0;
      inv_set_q    <= 1'b0;
      is_collide_q <= 1'b0;
      hit_q        <= 1'b0;
      scan_done_q  <= 1'b0;
      dead_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      eff_q        <= eff_d;
      idx_q        <= idx_d;
      hp_q         <= hp_d;
      invuln_q     <= invuln_d;
      inv_set_q    <= inv_set_d;
      is_collide_q <= is_collide_d;
      hit_q        <= hit_d;
      scan_done_q  <= scan_done_d;
      dead_q       <= dead_d;
    end
  end

  assign bullet_index = idx_q;
  assign is_collide   = is_collide_q;
  assign hp           = hp_q;
  assign hit          = hit_q;
  assign scan_done    = scan_done_q;
  assign dead         = dead_q;

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Directed bench for bullet_collision_scanner: a bullet-table model answers
// reads, and per-scan expectations are queued at start and compared at scan end.
module tb_bullet_collision_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] player_pos = {8'd50, 8'd50};
  logic [15:0] player_size = {8'd10, 8'd10};
  logic        player_moving = 1'b0;
  logic [15:0] bullet_pos, bullet_size;
  logic [1:0]  bullet_color;
  logic        bullet_render;
  logic [2:0]  bullet_index;
  logic        is_collide, hit, scan_done, dead;
  logic [7:0]  hp;

  logic [15:0] t_pos   [8];
  logic [15:0] t_size  [8];
  logic [1:0]  t_color [8];
  logic        t_render[8];

  typedef struct {
    int cycles;
    int ncol;
    int last_idx;
    int nhit;
    int hp;
    int dead;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  assign bullet_pos    = t_pos[bullet_index];
  assign bullet_size   = t_size[bullet_index];
  assign bullet_color  = t_color[bullet_index];
  assign bullet_render = t_render[bullet_index];

  always #5 clk = ~clk;

  bullet_collision_scanner dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .player_pos    (player_pos),
    .player_size   (player_size),
    .player_moving (player_moving),
    .bullet_pos    (bullet_pos),
    .bullet_size   (bullet_size),
    .bullet_color  (bullet_color),
    .bullet_render (bullet_render),
    .bullet_index  (bullet_index),
    .is_collide    (is_collide),
    .hp            (hp),
    .hit           (hit),
    .scan_done     (scan_done),
    .dead          (dead)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 8; i++) begin
      t_pos[i]    = 16'h0000;
      t_size[i]   = 16'h0000;
      t_color[i]  = 2'd0;
      t_render[i] = 1'b0;
    end
  endtask

  task automatic arm(input int slot, input int x, input int y, input int w, input int h,
                     input int color);
    t_pos[slot]    = {8'(x), 8'(y)};
    t_size[slot]   = {8'(w), 8'(h)};
    t_color[slot]  = 2'(color);
    t_render[slot] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One scan: expectations are queued at start, the table clears any bullet the
  // scanner reports, and the queued entry is checked once scan_done arrives.
  task automatic run_scan(input string tag, input int exp_cycles, input int exp_ncol,
                          input int exp_last, input int exp_nhit, input int exp_hp,
                          input int exp_dead, input bit trace);
    exp_t e, got;
    int   trace_err = 0;
    e = '{exp_cycles, exp_ncol, exp_last, exp_nhit, exp_hp, exp_dead};
    sb.push_back(e);
    got = '{-1, 0, -1, 0, 0, 0};
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (is_collide) begin
        got.ncol++;
        got.last_idx = int'(bullet_index);
        t_render[bullet_index] = 1'b0;
      end
      if (hit) got.nhit++;
      if (trace && (k % 2 == 1) && k <= 15 && int'(bullet_index) != (k - 1) / 2) trace_err++;
      if (scan_done) begin
        got.cycles = k;
        break;
      end
    end
    got.hp   = int'(hp);
    got.dead = int'(dead);
    e = sb.pop_front();
    check({tag, ".done_cycle"}, got.cycles, e.cycles);
    check({tag, ".collides"}, got.ncol, e.ncol);
    check({tag, ".collide_idx"}, got.last_idx, e.last_idx);
    check({tag, ".hits"}, got.nhit, e.nhit);
    check({tag, ".hp"}, got.hp, e.hp);
    check({tag, ".dead"}, got.dead, e.dead);
    if (trace) check({tag, ".index_trace_errs"}, trace_err, 0);
    $display("scan %s: cycles=%0d collides=%0d idx=%0d hits=%0d hp=%0d dead=%0d",
             tag, got.cycles, got.ncol, got.last_idx, got.nhit, got.hp, got.dead);
  endtask

  task automatic cooldown(input string tag, input int n, input int exp_hp);
    for (int s = 0; s < n; s++) begin
      t_render[2] = 1'b1;
      run_scan(tag, 17, 0, -1, 0, exp_hp, 0, 1'b0);
    end
  endtask

  initial begin
    int waited;
    clear_table();
    do_reset();

    #1;
    check("reset.hp", int'(hp), 20);
    check("reset.dead", int'(dead), 0);
    check("reset.is_collide", int'(is_collide), 0);
    check("reset.hit", int'(hit), 0);
    check("reset.scan_done", int'(scan_done), 0);
    check("reset.index", int'(bullet_index), 0);

    run_scan("empty", 17, 0, -1, 0, 20, 0, 1'b1);

    arm(2, 55, 55, 4, 4, 0);
    run_scan("white_hit", 18, 1, 2, 1, 16, 0, 1'b0);
    cooldown("invuln", 30, 16);
    t_render[2] = 1'b1;
    run_scan("after_invuln", 18, 1, 2, 1, 12, 0, 1'b0);

    // Blue bullets only hurt a moving heart; green heals past invulnerability.
    do_reset();
    clear_table();
    arm(2, 55, 55, 4, 4, 2);
    player_moving = 1'b0;
    run_scan("blue_still", 17, 0, -1, 0, 20, 0, 1'b0);
    player_moving = 1'b1;
    run_scan("blue_moving", 18, 1, 2, 1, 16, 0, 1'b0);
    player_moving = 1'b0;
    arm(2, 55, 55, 4, 4, 1);
    run_scan("green_18", 18, 1, 2, 0, 18, 0, 1'b0);
    t_render[2] = 1'b1;
    run_scan("green_20", 18, 1, 2, 0, 20, 0, 1'b0);
    t_render[2] = 1'b1;
    run_scan("green_cap", 18, 1, 2, 0, 20, 0, 1'b0);
    arm(2, 55, 55, 4, 4, 3);
    run_scan("color3", 17, 0, -1, 0, 20, 0, 1'b0);

    // First damage in a scan arms invulnerability; later white is blocked, green still heals.
    do_reset();
    clear_table();
    arm(1, 52, 52, 4, 4, 0);
    arm(3, 56, 56, 4, 4, 1);
    arm(5, 50, 58, 2, 2, 0);
    run_scan("mixed", 19, 2, 3, 1, 18, 0, 1'b0);

    do_reset();
    clear_table();
    arm(2, 60, 55, 4, 4, 0);
    run_scan("adjacent_x", 17, 0, -1, 0, 20, 0, 1'b0);
    arm(2, 55, 60, 4, 4, 0);
    run_scan("adjacent_y", 17, 0, -1, 0, 20, 0, 1'b0);
    arm(2, 55, 55, 0, 4, 0);
    run_scan("zero_width", 17, 0, -1, 0, 20, 0, 1'b0);
    arm(2, 59, 55, 4, 4, 0);
    run_scan("edge_in", 18, 1, 2, 1, 16, 0, 1'b0);

    // Grind HP down to zero; the final hit saturates at 0 and latches dead.
    cooldown("cd1", 30, 16);
    t_render[2] = 1'b1;
    run_scan("hit12", 18, 1, 2, 1, 12, 0, 1'b0);
    cooldown("cd2", 30, 12);
    t_render[2] = 1'b1;
    run_scan("hit8", 18, 1, 2, 1, 8, 0, 1'b0);
    cooldown("cd3", 30, 8);
    t_render[2] = 1'b1;
    run_scan("hit4", 18, 1, 2, 1, 4, 0, 1'b0);
    cooldown("cd4", 30, 4);
    t_render[2] = 1'b1;
    run_scan("hit0", 18, 1, 2, 1, 0, 1, 1'b0);
    t_render[2] = 1'b1;
    arm(4, 55, 55, 4, 4, 1);
    run_scan("dead_ignored", -1, 0, -1, 0, 0, 1, 1'b0);

    // Reset asserted while is_collide is high aborts the green heal in flight.
    do_reset();
    clear_table();
    arm(2, 55, 55, 4, 4, 0);
    run_scan("pre_abort", 18, 1, 2, 1, 16, 0, 1'b0);
    clear_table();
    arm(4, 55, 55, 4, 4, 1);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waited = 0;
    while (!is_collide && waited < 40) begin
      @(posedge clk);
      #1 waited++;
    end
    check("abort.collide_seen", int'(is_collide), 1);
    #2 reset = 1'b1;
    #1;
    check("abort.is_collide", int'(is_collide), 0);
    check("abort.hp", int'(hp), 20);
    check("abort.index", int'(bullet_index), 0);
    check("abort.scan_done", int'(scan_done), 0);
    $display("abort: reset during collide, hp=%0d is_collide=%0d", hp, is_collide);
    @(negedge clk);
    reset = 1'b0;
    clear_table();
    arm(2, 55, 55, 4, 4, 0);
    run_scan("post_abort", 18, 1, 2, 1, 16, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
